// File: rtl/branch_predictor_pkg.sv
// rtl/branch_predictor_pkg.sv - shared defaults and counter constants for the branch predictor
package branch_predictor_pkg;

  localparam int DEF_ADDR_W = 32;
  localparam int DEF_IDX_W  = 6;
  localparam int DEF_TAG_W  = 8;
  localparam int DEF_CNT_W  = 2;
  localparam int DEF_HIST_W = 4;
  localparam int DEF_STAT_W = 16;

  // Weakly-taken reset value keeps the old predict-taken bias for cold entries.
  function automatic int weak_taken(input int cnt_w);
    return 1 << (cnt_w - 1);
  endfunction

  function automatic int sat_max(input int cnt_w);
    return (1 << cnt_w) - 1;
  endfunction

endpackage

// File: rtl/branch_predictor_sat_counter.sv
// rtl/branch_predictor_sat_counter.sv - combinational up/down saturating counter step
module sat_counter
  import branch_predictor_pkg::*;
#(
  parameter int CNT_W = DEF_CNT_W
) (
  input  logic [CNT_W-1:0] cnt,
  input  logic             up,
  output logic [CNT_W-1:0] next
);

  localparam logic [CNT_W-1:0] SAT_MAX = CNT_W'(sat_max(CNT_W));

  always_comb begin
    next = cnt;
    if (up) begin
      if (cnt != SAT_MAX) next = cnt + 1'b1;
    end else if (cnt != '0) begin
      next = cnt - 1'b1;
    end
  end

endmodule

// File: rtl/branch_predictor.sv
// rtl/branch_predictor.sv - BTB plus gshare PHT predictor with non-speculative history
module branch_predictor
  import branch_predictor_pkg::*;
#(
  parameter int ADDR_W = DEF_ADDR_W,
  parameter int IDX_W  = DEF_IDX_W,
  parameter int TAG_W  = DEF_TAG_W,
  parameter int CNT_W  = DEF_CNT_W,
  parameter int HIST_W = DEF_HIST_W,
  parameter int STAT_W = DEF_STAT_W
) (
  input  logic                                   clk_i,
  input  logic                                   rst_i,
  input  logic [ADDR_W-1:0]                      lookup_pc_i,
  output logic                                   pred_hit_o,
  output logic                                   pred_taken_o,
  output logic [ADDR_W-1:0]                      pred_target_o,
  output logic [((HIST_W > 0) ? HIST_W : 1)-1:0] pred_hist_o,
  input  logic                                   upd_valid_i,
  input  logic [ADDR_W-1:0]                      upd_pc_i,
  input  logic [((HIST_W > 0) ? HIST_W : 1)-1:0] upd_hist_i,
  input  logic                                   upd_taken_i,
  input  logic [ADDR_W-1:0]                      upd_target_i,
  input  logic                                   upd_mispredict_i,
  output logic [STAT_W-1:0]                      branch_cnt_o,
  output logic [STAT_W-1:0]                      mispred_cnt_o
);

  localparam int ENTRIES = 1 << IDX_W;
  localparam int HW      = (HIST_W > 0) ? HIST_W : 1;
  localparam logic [CNT_W-1:0] WEAK_TAKEN = CNT_W'(weak_taken(CNT_W));

  typedef struct packed {
    logic              valid;
    logic [TAG_W-1:0]  tag;
    logic [ADDR_W-1:0] target;
  } btb_entry_t;

  btb_entry_t       btb [ENTRIES];
  logic [CNT_W-1:0] pht [ENTRIES];
  logic [HW-1:0]    ghr;

  logic [IDX_W-1:0] lk_idx;
  logic [IDX_W-1:0] upd_idx;
  logic [IDX_W-1:0] upd_btb_idx;
  btb_entry_t       lk_entry;
  logic [CNT_W-1:0] pht_next;

  // History is zero-extended into the index; bimodal mode contributes nothing.
  function automatic logic [IDX_W-1:0] pht_index(input logic [ADDR_W-1:0] pc,
                                                 input logic [HW-1:0]     hist);
    logic [IDX_W-1:0] h;
    h = '0;
    if (HIST_W > 0) h[HW-1:0] = hist;
    return pc[IDX_W-1:0] ^ h;
  endfunction

  if (ADDR_W > IDX_W + TAG_W) begin : g_high_bits
    logic unused_pc_bits;
    assign unused_pc_bits = ^{lookup_pc_i[ADDR_W-1:IDX_W+TAG_W], upd_pc_i[ADDR_W-1:IDX_W+TAG_W]};
  end

  always_comb begin
    lk_idx        = pht_index(lookup_pc_i, ghr);
    lk_entry      = btb[lookup_pc_i[IDX_W-1:0]];
    pred_hit_o    = lk_entry.valid && (lk_entry.tag == lookup_pc_i[IDX_W+TAG_W-1:IDX_W]);
    pred_taken_o  = pred_hit_o && pht[lk_idx][CNT_W-1];
    pred_target_o = pred_hit_o ? lk_entry.target : '0;
    pred_hist_o   = ghr;
    upd_idx       = pht_index(upd_pc_i, upd_hist_i);
    upd_btb_idx   = upd_pc_i[IDX_W-1:0];
  end

  sat_counter #(.CNT_W(CNT_W)) u_pht_cnt (
    .cnt  (pht[upd_idx]),
    .up   (upd_taken_i),
    .next (pht_next)
  );

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      for (int i = 0; i < ENTRIES; i++) begin
        btb[i] <= '0;
        pht[i] <= WEAK_TAKEN;
      end
      ghr           <= '0;
      branch_cnt_o  <= '0;
      mispred_cnt_o <= '0;
    end else if (upd_valid_i) begin
      pht[upd_idx] <= pht_next;
      if (upd_taken_i) begin
        btb[upd_btb_idx] <= '{valid: 1'b1, tag: upd_pc_i[IDX_W+TAG_W-1:IDX_W], target: upd_target_i};
      end
      // Shifting in the low HW bits of {ghr, taken} drops the oldest outcome.
      if (HIST_W > 0) ghr <= HW'({ghr, upd_taken_i});
      if (branch_cnt_o != '1) branch_cnt_o <= branch_cnt_o + 1'b1;
      if (upd_mispredict_i && (mispred_cnt_o != '1)) mispred_cnt_o <= mispred_cnt_o + 1'b1;
    end
  end

endmodule

// File: tb/tb_branch_predictor.sv
// tb/tb_branch_predictor.sv - directed checks on gshare, bimodal and narrow-statistics builds
module tb_branch_predictor;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [31:0] lookup_pc = '0;
  logic [2:0]  vmask = '0;
  logic [31:0] upd_pc = '0;
  logic [3:0]  upd_hist = '0;
  logic        upd_taken = 1'b0;
  logic [31:0] upd_target = '0;
  logic        upd_mis = 1'b0;

  logic        a_hit, a_taken, b_hit, b_taken, c_hit, c_taken;
  logic [31:0] a_target, b_target, c_target;
  logic [3:0]  a_hist, c_hist;
  logic [0:0]  b_hist;
  logic [15:0] a_bcnt, a_mcnt, b_bcnt, b_mcnt;
  logic [3:0]  c_bcnt, c_mcnt;

  int checks = 0;
  int errors = 0;
  logic exp_taken [4] = '{1'b1, 1'b0, 1'b0, 1'b0};

  always #5 clk = ~clk;

  branch_predictor u_a (
    .clk_i(clk), .rst_i(rst), .lookup_pc_i(lookup_pc),
    .pred_hit_o(a_hit), .pred_taken_o(a_taken), .pred_target_o(a_target), .pred_hist_o(a_hist),
    .upd_valid_i(vmask[0]), .upd_pc_i(upd_pc), .upd_hist_i(upd_hist), .upd_taken_i(upd_taken),
    .upd_target_i(upd_target), .upd_mispredict_i(upd_mis),
    .branch_cnt_o(a_bcnt), .mispred_cnt_o(a_mcnt)
  );

  branch_predictor #(.HIST_W(0)) u_b (
    .clk_i(clk), .rst_i(rst), .lookup_pc_i(lookup_pc),
    .pred_hit_o(b_hit), .pred_taken_o(b_taken), .pred_target_o(b_target), .pred_hist_o(b_hist),
    .upd_valid_i(vmask[1]), .upd_pc_i(upd_pc), .upd_hist_i(upd_hist[0:0]), .upd_taken_i(upd_taken),
    .upd_target_i(upd_target), .upd_mispredict_i(upd_mis),
    .branch_cnt_o(b_bcnt), .mispred_cnt_o(b_mcnt)
  );

  branch_predictor #(.STAT_W(4)) u_c (
    .clk_i(clk), .rst_i(rst), .lookup_pc_i(lookup_pc),
    .pred_hit_o(c_hit), .pred_taken_o(c_taken), .pred_target_o(c_target), .pred_hist_o(c_hist),
    .upd_valid_i(vmask[2]), .upd_pc_i(upd_pc), .upd_hist_i(upd_hist), .upd_taken_i(upd_taken),
    .upd_target_i(upd_target), .upd_mispredict_i(upd_mis),
    .branch_cnt_o(c_bcnt), .mispred_cnt_o(c_mcnt)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  task automatic upd(input logic [2:0] mask, input logic [31:0] pc, input logic [3:0] hist,
                     input logic taken, input logic [31:0] target, input logic mis);
    upd_pc = pc; upd_hist = hist; upd_taken = taken; upd_target = target; upd_mis = mis;
    vmask = mask;
    @(posedge clk); #1;
    vmask = '0;
  endtask

  task automatic look(input logic [31:0] pc);
    lookup_pc = pc;
    #1;
  endtask

  initial begin
    #12 rst = 1'b0;
    look(32'h10);
    chk("rst_hit", 32'(a_hit), 32'd0);
    chk("rst_taken", 32'(a_taken), 32'd0);
    chk("rst_target", a_target, 32'd0);
    chk("rst_hist", 32'(a_hist), 32'd0);
    chk("rst_bcnt", 32'(a_bcnt), 32'd0);
    chk("rst_mcnt", 32'(a_mcnt), 32'd0);

    // First taken install; lookup then indexes PHT[0x11] which is still weakly taken.
    upd(3'b001, 32'h10, 4'h0, 1'b1, 32'h40, 1'b1);
    look(32'h10);
    chk("inst_hit", 32'(a_hit), 32'd1);
    chk("inst_taken", 32'(a_taken), 32'd1);
    chk("inst_target", a_target, 32'h40);
    chk("inst_hist", 32'(a_hist), 32'd1);
    chk("inst_bcnt", 32'(a_bcnt), 32'd1);
    chk("inst_mcnt", 32'(a_mcnt), 32'd1);
    repeat (2) @(posedge clk);
    #1;
    chk("idle_mcnt", 32'(a_mcnt), 32'd1);

    // Drive PHT[0x07] to 1 and GHR to all-ones so the same entry is read and written.
    upd(3'b001, 32'h08, 4'hF, 1'b0, 32'h0, 1'b0);
    upd(3'b001, 32'h08, 4'h0, 1'b1, 32'h20, 1'b0);
    repeat (3) upd(3'b001, 32'h30, 4'h0, 1'b1, 32'h1, 1'b0);
    look(32'h08);
    chk("gh_hist", 32'(a_hist), 32'hF);
    chk("gh_hit", 32'(a_hit), 32'd1);
    chk("gh_taken", 32'(a_taken), 32'd0);
    upd_pc = 32'h08; upd_hist = 4'hF; upd_taken = 1'b1; upd_target = 32'h20; upd_mis = 1'b0;
    vmask = 3'b001;
    #1;
    chk("same_cycle_taken", 32'(a_taken), 32'd0);
    @(posedge clk); #1;
    vmask = '0;
    #1;
    chk("next_cycle_taken", 32'(a_taken), 32'd1);
    chk("next_cycle_target", a_target, 32'h20);
    chk("next_cycle_hist", 32'(a_hist), 32'hF);
    chk("a_bcnt", 32'(a_bcnt), 32'd7);
    chk("a_mcnt", 32'(a_mcnt), 32'd1);

    // Bimodal build: counter saturates at 0 and climbs back without wrapping.
    upd(3'b010, 32'h05, 4'h0, 1'b1, 32'h50, 1'b0);
    look(32'h05);
    chk("bi_hit", 32'(b_hit), 32'd1);
    chk("bi_taken", 32'(b_taken), 32'd1);
    chk("bi_target", b_target, 32'h50);
    chk("bi_hist", 32'(b_hist), 32'd0);
    for (int i = 0; i < 4; i++) begin
      upd(3'b010, 32'h05, 4'h0, 1'b0, 32'h0, 1'b0);
      chk($sformatf("bi_nt%0d_taken", i), 32'(b_taken), 32'(exp_taken[i]));
    end
    chk("bi_sat_hit", 32'(b_hit), 32'd1);
    upd(3'b010, 32'h05, 4'h0, 1'b1, 32'h50, 1'b0);
    chk("bi_up1_taken", 32'(b_taken), 32'd0);

    // Same index, different tag evicts the 0x05 entry.
    upd(3'b010, 32'h45, 4'h0, 1'b1, 32'h99, 1'b0);
    look(32'h05);
    chk("alias_old_hit", 32'(b_hit), 32'd0);
    chk("alias_old_taken", 32'(b_taken), 32'd0);
    chk("alias_old_target", b_target, 32'd0);
    look(32'h45);
    chk("alias_new_hit", 32'(b_hit), 32'd1);
    chk("alias_new_taken", 32'(b_taken), 32'd1);
    chk("alias_new_target", b_target, 32'h99);
    chk("b_bcnt", 32'(b_bcnt), 32'd7);

    // Narrow statistics saturate at 15.
    upd_pc = 32'h10; upd_hist = 4'h0; upd_taken = 1'b1; upd_target = 32'h40; upd_mis = 1'b1;
    vmask = 3'b100;
    for (int i = 0; i < 20; i++) begin
      @(posedge clk); #1;
      if (i == 13) chk("c_mcnt14", 32'(c_mcnt), 32'd14);
    end
    chk("c_mcnt_sat", 32'(c_mcnt), 32'd15);
    chk("c_bcnt_sat", 32'(c_bcnt), 32'd15);

    // Asynchronous reset while an update is still being driven.
    rst = 1'b1;
    lookup_pc = 32'h08;
    #1;
    chk("arst_c_mcnt", 32'(c_mcnt), 32'd0);
    chk("arst_c_bcnt", 32'(c_bcnt), 32'd0);
    chk("arst_a_hit", 32'(a_hit), 32'd0);
    chk("arst_a_taken", 32'(a_taken), 32'd0);
    chk("arst_a_target", a_target, 32'd0);
    chk("arst_a_hist", 32'(a_hist), 32'd0);
    chk("arst_a_bcnt", 32'(a_bcnt), 32'd0);
    chk("arst_c_hit", 32'(c_hit), 32'd0);
    vmask = '0;
    @(posedge clk); #1;
    rst = 1'b0;
    @(posedge clk); #1;
    chk("post_rst_c_mcnt", 32'(c_mcnt), 32'd0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
